// File: rtl/hex_display_driver.sv
// Seven-segment driver for the calculator front panel.
// It shows a window of a glyph buffer and supports static display, wrap-around scrolling and per-digit blinking.
module hex_display_driver #(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_LEN    = 8,
    parameter int SCROLL_DIV = 25000000,
    parameter int BLINK_DIV  = 12500000,
    localparam int AW        = (MSG_LEN > 2) ? $clog2(MSG_LEN) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [4:0]              wr_data,
    input  logic                    mode,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic [AW-1:0]           scroll_pos
);

    localparam int SCW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [4:0]              buffer [MSG_LEN];
    logic [SCW-1:0]          scroll_cnt;
    logic [BCW-1:0]          blink_cnt;
    logic                    blink_phase;
    logic [7*NUM_DIGITS-1:0] next_hex;

    // Segment patterns are gfedcba, active-low; unused codes blank the digit.
    function automatic logic [6:0] decode(input logic [4:0] code);
        case (code)
            5'h00:   decode = 7'b1000000;
            5'h01:   decode = 7'b1111001;
            5'h02:   decode = 7'b0100100;
            5'h03:   decode = 7'b0110000;
            5'h04:   decode = 7'b0011001;
            5'h05:   decode = 7'b0010010;
            5'h06:   decode = 7'b0000010;
            5'h07:   decode = 7'b1111000;
            5'h08:   decode = 7'b0000000;
            5'h09:   decode = 7'b0011000;
            5'h0A:   decode = 7'b0001000;
            5'h0B:   decode = 7'b0000011;
            5'h0C:   decode = 7'b1000110;
            5'h0D:   decode = 7'b0100001;
            5'h0E:   decode = 7'b0000110;
            5'h0F:   decode = 7'b0001110;
            5'h10:   decode = 7'b0001100;
            5'h11:   decode = 7'b0001001;
            5'h12:   decode = 7'b1100011;
            5'h13:   decode = 7'b1000111;
            5'h14:   decode = 7'b0101011;
            5'h16:   decode = 7'b0001111;
            5'h17:   decode = 7'b0100011;
            5'h18:   decode = 7'b0000111;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // pos < MSG_LEN and the offset is < NUM_DIGITS <= MSG_LEN,
    // so a single conditional subtract is enough for the modulo.
    function automatic logic [AW-1:0] digit_index(input logic [AW-1:0] pos, input int k);
        logic [AW:0] sum;
        sum = {1'b0, pos} + (AW+1)'(NUM_DIGITS - 1 - k);
        if (sum >= (AW+1)'(MSG_LEN))
            sum = sum - (AW+1)'(MSG_LEN);
        return sum[AW-1:0];
    endfunction

    always_comb begin
        next_hex = '1;
        if (enable) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                next_hex[7*k +: 7] = decode(buffer[digit_index(scroll_pos, k)]);
                if (blink_mask[k] && !blink_phase)
                    next_hex[7*k +: 7] = 7'b1111111;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++)
                buffer[i] <= 5'h1F;
            hex_out     <= '1;
            scroll_pos  <= '0;
            scroll_cnt  <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            if (wr_en && (int'(wr_addr) < MSG_LEN))
                buffer[wr_addr] <= wr_data;

            hex_out <= next_hex;

            // Static mode pins the window to the start of the message.
            if (!mode) begin
                scroll_pos <= '0;
                scroll_cnt <= '0;
            end else if (enable) begin
                if (scroll_cnt == SCW'(SCROLL_DIV - 1)) begin
                    scroll_cnt <= '0;
                    if (scroll_pos == AW'(MSG_LEN - 1))
                        scroll_pos <= '0;
                    else
                        scroll_pos <= scroll_pos + AW'(1);
                end else begin
                    scroll_cnt <= scroll_cnt + SCW'(1);
                end
            end

            if (enable) begin
                if (blink_cnt == BCW'(BLINK_DIV - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed bench for hex_display_driver with 4 digits, a 6-entry buffer, SCROLL_DIV=3 and BLINK_DIV=2.
module tb_hex_display_driver;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [4:0]  wr_data;
    logic        mode;
    logic [3:0]  blink_mask;
    logic [27:0] hex_out;
    logic [2:0]  scroll_pos;

    int checkCount = 0;
    int errorCount = 0;

    localparam logic [27:0] ALL_BLANK = 28'hFFFFFFF;
    localparam logic [6:0]  G0 = 7'b1000000;
    localparam logic [6:0]  G1 = 7'b1111001;
    localparam logic [6:0]  G2 = 7'b0100100;
    localparam logic [6:0]  G3 = 7'b0110000;
    localparam logic [6:0]  G4 = 7'b0011001;
    localparam logic [6:0]  G5 = 7'b0010010;
    localparam logic [6:0]  GB = 7'b1111111;

    hex_display_driver #(
        .NUM_DIGITS(4),
        .MSG_LEN(6),
        .SCROLL_DIV(3),
        .BLINK_DIV(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .mode(mode),
        .blink_mask(blink_mask),
        .hex_out(hex_out),
        .scroll_pos(scroll_pos)
    );

    always #5 clk = ~clk;

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic [4:0] data);
        wr_en   = we;
        wr_addr = addr;
        wr_data = data;
        waitCycle();
    endtask

    task automatic checkOutput(input string tag, input logic [27:0] observed, input logic [27:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        clk        = 1'b0;
        reset      = 1'b1;
        enable     = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = 3'd0;
        wr_data    = 5'd0;
        mode       = 1'b0;
        blink_mask = 4'b0000;

        waitCycle();
        waitCycle();
        checkOutput("reset_hex", hex_out, ALL_BLANK);
        checkOutput("reset_pos", {25'd0, scroll_pos}, 28'd0);

        reset = 1'b0;
        repeat (3) waitCycle();
        checkOutput("blank_after_reset", hex_out, ALL_BLANK);

        // Static decode of 1,2,3,4 in buffer[0..3]
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 3'(i), 5'(i + 1));
        applyStimulus(1'b0, 3'd0, 5'd0);
        checkOutput("static_decode", hex_out, {G1, G2, G3, G4});
        checkOutput("static_pos", {25'd0, scroll_pos}, 28'd0);

        // Out-of-range addresses must not disturb the display
        applyStimulus(1'b1, 3'd6, 5'h08);
        applyStimulus(1'b1, 3'd7, 5'h08);
        applyStimulus(1'b0, 3'd0, 5'd0);
        checkOutput("addr_out_of_range", hex_out, {G1, G2, G3, G4});

        applyStimulus(1'b1, 3'd3, 5'h15);
        applyStimulus(1'b0, 3'd0, 5'd0);
        checkOutput("code_15_blank", hex_out, {G1, G2, G3, GB});
        applyStimulus(1'b1, 3'd2, 5'h1F);
        applyStimulus(1'b0, 3'd0, 5'd0);
        checkOutput("code_1F_blank", hex_out, {G1, G2, GB, GB});

        // Scroll wrap with buffer = 0..5
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 3'(i), 5'(i));
        applyStimulus(1'b0, 3'd0, 5'd0);
        mode = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            waitCycle();
            if (c % 3 == 0)
                checkOutput($sformatf("scroll_pos_step%0d", c / 3), {25'd0, scroll_pos}, 28'((c / 3) % 6));
            if (c == 13)
                checkOutput("scroll_window_pos4", hex_out, {G4, G5, G0, G1});
        end

        // Freeze with enable=0 at scroll_pos 3, counter mid-count
        repeat (10) waitCycle();
        checkOutput("pre_disable_pos", {25'd0, scroll_pos}, 28'd3);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            waitCycle();
            checkOutput($sformatf("disabled_hex%0d", i), hex_out, ALL_BLANK);
            checkOutput($sformatf("disabled_pos%0d", i), {25'd0, scroll_pos}, 28'd3);
        end
        enable = 1'b1;
        waitCycle();
        checkOutput("resume_pos_hold", {25'd0, scroll_pos}, 28'd3);
        checkOutput("resume_hex", hex_out, {G3, G4, G5, G0});
        waitCycle();
        checkOutput("resume_pos_step", {25'd0, scroll_pos}, 28'd4);

        mode = 1'b0;
        waitCycle();
        checkOutput("mode_static_pos", {25'd0, scroll_pos}, 28'd0);

        // Blink on digit 0; the blink phase is known exactly from reset
        reset = 1'b1;
        waitCycle();
        waitCycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 3'(i), 5'(i));
        wr_en      = 1'b0;
        blink_mask = 4'b0001;
        for (int e = 5; e <= 12; e++) begin
            waitCycle();
            checkOutput($sformatf("blink_edge%0d", e), hex_out,
                        {G0, G1, G2, ((e % 4 == 3) || (e % 4 == 0)) ? GB : G3});
        end

        // Reset in the middle of a scroll
        blink_mask = 4'b0000;
        mode       = 1'b1;
        repeat (9) waitCycle();
        checkOutput("pre_reset_pos", {25'd0, scroll_pos}, 28'd3);
        reset = 1'b1;
        waitCycle();
        checkOutput("midscroll_reset_pos", {25'd0, scroll_pos}, 28'd0);
        checkOutput("midscroll_reset_hex", hex_out, ALL_BLANK);
        reset = 1'b0;
        waitCycle();
        checkOutput("after_reset_hex", hex_out, ALL_BLANK);
        repeat (2) waitCycle();
        checkOutput("after_reset_buffer_blank", hex_out, ALL_BLANK);
        checkOutput("after_reset_scroll", {25'd0, scroll_pos}, 28'd1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
